// File: rtl/exc_sequencer_if.sv
// exc_sequencer_if: commit/interrupt inputs and CP0/fetch outputs of the exception sequencer
interface exc_sequencer_if;
    logic        commit_valid;
    logic [31:0] commit_pc;
    logic        is_syscall;
    logic        is_eret;
    logic [5:0]  intr;
    logic        intimer;
    logic [31:0] status;
    logic [31:0] cause;
    logic [31:0] epc;
    logic [31:0] excptype;
    logic [31:0] excp_pc;
    logic        flush;
    logic        stall;
    logic        new_pc_valid;
    logic [31:0] new_pc;
    modport master (
        output commit_valid, commit_pc, is_syscall, is_eret, intr, intimer, status, cause, epc,
        input  excptype, excp_pc, flush, stall, new_pc_valid, new_pc
    );
    modport slave (
        input  commit_valid, commit_pc, is_syscall, is_eret, intr, intimer, status, cause, epc,
        output excptype, excp_pc, flush, stall, new_pc_valid, new_pc
    );
endinterface

// File: rtl/exc_sequencer.sv
// exc_sequencer: arbitrates interrupt/syscall/eret, pulses excptype to CP0, flushes, then redirects fetch
// Optional: define EXC_SEQ_SW_INT_EN to let software interrupts (Status/Cause bits 9:8) raise int_req.
module exc_sequencer #(
    parameter logic [31:0] EXC_VECTOR = 32'h0000_0040,
    parameter int unsigned DRAIN_CYC  = 3
) (
    input logic            clk,
    input logic            rst,
    exc_sequencer_if.slave bus
);
    typedef enum logic [1:0] {IDLE, EXC, DRAIN, REDIR} state_t;
    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        eret_q, eret_d;
    logic [31:0] excptype_q, excptype_d;
    logic [31:0] excp_pc_q, excp_pc_d;
    logic        flush_q, flush_d;
    logic        stall_q, stall_d;
    logic        npv_q, npv_d;
    logic [31:0] new_pc_q, new_pc_d;
    logic [5:0]  ip;
    logic        int_req;
    logic        unused_bits;
    assign ip = {bus.intr[5:1], bus.intr[0] | bus.intimer};
`ifdef EXC_SEQ_SW_INT_EN
    assign int_req = bus.status[0] & ~bus.status[1] &
                     (|(bus.status[15:10] & ip) | |(bus.status[9:8] & bus.cause[9:8]));
    assign unused_bits = ^{bus.status[31:16], bus.status[7:2], bus.cause[31:10], bus.cause[7:0]};
`else
    assign int_req = bus.status[0] & ~bus.status[1] & |(bus.status[15:10] & ip);
    assign unused_bits = ^{bus.status[31:16], bus.status[9:2], bus.cause};
`endif
    // next state and next registered outputs; outputs default to idle values
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        eret_d     = eret_q;
        excptype_d = 32'h0;
        excp_pc_d  = excp_pc_q;
        flush_d    = 1'b0;
        stall_d    = 1'b0;
        npv_d      = 1'b0;
        new_pc_d   = new_pc_q;
        case (state_q)
            IDLE: if (bus.commit_valid && (int_req || bus.is_syscall || bus.is_eret)) begin
                state_d    = EXC;
                excptype_d = int_req ? 32'h4 : bus.is_syscall ? 32'h100 : 32'h200;
                eret_d     = !int_req && !bus.is_syscall;
                excp_pc_d  = bus.commit_pc;
                flush_d    = 1'b1;
                stall_d    = 1'b1;
                cnt_d      = 4'(DRAIN_CYC - 1);
            end
            EXC: begin
                new_pc_d = eret_q ? bus.epc : EXC_VECTOR;
                stall_d  = 1'b1;
                state_d  = (DRAIN_CYC == 1) ? REDIR : DRAIN;
                npv_d    = (DRAIN_CYC == 1);
                flush_d  = (DRAIN_CYC != 1);
            end
            DRAIN: begin
                cnt_d   = cnt_q - 4'd1;
                stall_d = 1'b1;
                state_d = (cnt_q == 4'd1) ? REDIR : DRAIN;
                npv_d   = (cnt_q == 4'd1);
                flush_d = (cnt_q != 4'd1);
            end
            default: state_d = IDLE;
        endcase
    end
    // state and output registers, cleared asynchronously so reset aborts any sequence
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            eret_q     <= 1'b0;
            excptype_q <= '0;
            excp_pc_q  <= '0;
            flush_q    <= 1'b0;
            stall_q    <= 1'b0;
            npv_q      <= 1'b0;
            new_pc_q   <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            eret_q     <= eret_d;
            excptype_q <= excptype_d;
            excp_pc_q  <= excp_pc_d;
            flush_q    <= flush_d;
            stall_q    <= stall_d;
            npv_q      <= npv_d;
            new_pc_q   <= new_pc_d;
        end
    end
    assign bus.excptype     = excptype_q;
    assign bus.excp_pc      = excp_pc_q;
    assign bus.flush        = flush_q;
    assign bus.stall        = stall_q;
    assign bus.new_pc_valid = npv_q;
    assign bus.new_pc       = new_pc_q;
endmodule

// File: tb/tb_exc_sequencer.sv
// tb_exc_sequencer: randomized scoreboard bench for exc_sequencer with a rule-level reference model
module tb_exc_sequencer;
    localparam logic [31:0] VEC   = 32'h0000_0040;
    localparam int          DRAIN = 3;
    typedef struct {
        logic [31:0] code;
        logic [31:0] pc;
        logic [31:0] npc;
    } exp_t;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   ntests = 0;
    int   nfail  = 0;
    int   nseq   = 0;
    int   busy   = 0;
    exp_t q[$];
    exc_sequencer_if sq();
    exc_sequencer #(.EXC_VECTOR(VEC), .DRAIN_CYC(DRAIN)) dut (.clk(clk), .rst(rst), .bus(sq));
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        ntests++;
        if (act !== req) begin
            nfail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, req, $time);
        end
    endtask

    function automatic bit model_int(input logic [31:0] st, input logic [31:0] ca,
                                     input logic [5:0] ir, input logic tm);
        bit pend = 0;
        for (int i = 0; i < 6; i++)
            if (st[10+i] && (ir[i] || (i == 0 && tm))) pend = 1;
`ifdef EXC_SEQ_SW_INT_EN
        for (int i = 0; i < 2; i++)
            if (st[8+i] && ca[8+i]) pend = 1;
`endif
        return st[0] && !st[1] && pend;
    endfunction

    task automatic step(input logic cv, input logic [31:0] pc, input logic sys, input logic er,
                        input logic [5:0] ir, input logic tm, input logic [31:0] st,
                        input logic [31:0] ca, input logic [31:0] ep);
        bit   irq;
        exp_t e;
        sq.commit_valid = cv; sq.commit_pc = pc; sq.is_syscall = sys; sq.is_eret = er;
        sq.intr = ir; sq.intimer = tm; sq.status = st; sq.cause = ca; sq.epc = ep;
        irq = model_int(st, ca, ir, tm);
        if (busy > 0) busy--;
        else if (cv && (irq || sys || er)) begin
            e.code = irq ? 32'h4 : sys ? 32'h100 : 32'h200;
            e.pc   = pc;
            e.npc  = (irq || sys) ? VEC : ep;
            q.push_back(e);
            busy = DRAIN + 1;
        end
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n, input logic [31:0] ep);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, ep);
    endtask

    initial begin : monitor
        int          phase = 0;
        logic [31:0] exp_npc = 0;
        exp_t        e;
        forever begin
            @(negedge clk);
            if (!rst) phase = 0;
            else if (phase == 0) begin
                if (sq.excptype != 0) begin
                    if (q.size() == 0) chk("unexpected_excptype", sq.excptype, 0);
                    else begin
                        e = q.pop_front();
                        nseq++;
                        chk("excptype", sq.excptype, e.code);
                        chk("excp_pc", sq.excp_pc, e.pc);
                        chk("exc_flush_stall_npv", {29'b0, sq.flush, sq.stall, sq.new_pc_valid}, 32'b110);
                        exp_npc = e.npc;
                        phase = 1;
                    end
                end else chk("idle_flush_stall_npv", {29'b0, sq.flush, sq.stall, sq.new_pc_valid}, 0);
            end else if (phase < DRAIN) begin
                chk("drain_excptype", sq.excptype, 0);
                chk("drain_flush_stall_npv", {29'b0, sq.flush, sq.stall, sq.new_pc_valid}, 32'b110);
                phase++;
            end else begin
                chk("redir_excptype", sq.excptype, 0);
                chk("redir_flush_stall_npv", {29'b0, sq.flush, sq.stall, sq.new_pc_valid}, 32'b011);
                chk("new_pc", sq.new_pc, exp_npc);
                phase = 0;
            end
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin : driver
        logic [31:0] st, ep, ca;
        logic        cv, sys, er, tm;
        logic [5:0]  ir;
        sq.commit_valid = 0; sq.commit_pc = 0; sq.is_syscall = 0; sq.is_eret = 0;
        sq.intr = 0; sq.intimer = 0; sq.status = 0; sq.cause = 0; sq.epc = 0;
        #1;
        chk("rst_excptype", sq.excptype, 0);
        chk("rst_excp_pc", sq.excp_pc, 0);
        chk("rst_new_pc", sq.new_pc, 0);
        chk("rst_flags", {29'b0, sq.flush, sq.stall, sq.new_pc_valid}, 0);
        repeat (3) @(posedge clk);
        #1 rst = 1;
        idle(2, 0);
        // syscall
        step(1, 32'h100, 1, 0, 0, 0, 32'h1000_0001, 0, 0);
        idle(DRAIN + 2, 0);
        // timer interrupt, then blocked by EXL, then blocked by IE=0
        step(1, 32'h200, 0, 0, 0, 1, 32'h1000_0401, 0, 0);
        idle(DRAIN + 2, 0);
        step(1, 32'h200, 0, 0, 0, 1, 32'h1000_0403, 0, 0);
        idle(2, 0);
        step(1, 32'h200, 0, 0, 0, 1, 32'h1000_0400, 0, 0);
        idle(2, 0);
        // eret with a syscall request arriving during drain
        step(1, 32'h300, 0, 1, 0, 0, 32'h1000_0000, 0, 32'h104);
        step(0, 0, 0, 0, 0, 0, 0, 0, 32'h104);
        step(1, 32'h400, 1, 0, 0, 0, 32'h1000_0001, 0, 32'h104);
        idle(DRAIN + 2, 32'h104);
        // interrupt beats syscall
        step(1, 32'h300, 1, 0, 6'b000100, 0, 32'h0000_1001, 0, 0);
        idle(DRAIN + 2, 0);
        // software interrupt
        step(1, 32'h500, 0, 0, 0, 0, 32'h0000_0101, 32'h0000_0100, 0);
        idle(DRAIN + 2, 0);
        // back-to-back: request in first IDLE after redirect
        step(1, 32'h600, 1, 0, 0, 0, 0, 0, 0);
        idle(DRAIN + 1, 0);
        step(1, 32'h604, 0, 1, 0, 0, 0, 0, 32'h888);
        idle(DRAIN + 2, 32'h888);
        // reset in the middle of drain aborts with no redirect
        step(1, 32'h700, 1, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0);
        rst = 0;
        #1;
        chk("midrst_excptype", sq.excptype, 0);
        chk("midrst_excp_pc", sq.excp_pc, 0);
        chk("midrst_new_pc", sq.new_pc, 0);
        chk("midrst_flags", {29'b0, sq.flush, sq.stall, sq.new_pc_valid}, 0);
        q.delete();
        busy = 0;
        @(posedge clk); #1 rst = 1;
        idle(DRAIN + 4, 0);
        // randomized traffic
        ep = $urandom;
        for (int n = 0; n < 1500; n++) begin
            cv  = ($urandom_range(0, 1) == 1);
            sys = ($urandom_range(0, 3) == 0);
            er  = ($urandom_range(0, 3) == 0);
            ir  = ($urandom_range(0, 3) == 0) ? 6'($urandom) : 6'b0;
            tm  = ($urandom_range(0, 5) == 0);
            st  = $urandom;
            st[0] = ($urandom_range(0, 3) != 0);
            st[1] = ($urandom_range(0, 3) == 0);
            ca  = $urandom;
            if (busy == 0) ep = $urandom;
            step(cv, $urandom, sys, er, ir, tm, st, ca, ep);
        end
        idle(DRAIN + 3, ep);
        chk("queue_drained", q.size(), 0);
        ntests++;
        if (nseq < 20) begin
            nfail++;
            $display("FAIL seq_count: got %0d expected at least 20", nseq);
        end
        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end
endmodule

// File: doc/exc_sequencer.md
Name: exc_sequencer

Overview:
- Exception/interrupt sequencer for the CP0 coprocessor.
- Watches committed instructions (syscall, eret) and the interrupt sources (hardware intr lines, CP0 timer intimer).
- Arbitrates among them and drives a one-cycle excptype code plus exception pc into CP0.
- Flushes and stalls the pipeline, then redirects fetch to the handler vector or to EPC.

Parameters:
EXC_VECTOR, 32'h0000_0040, handler entry address for interrupt and syscall
DRAIN_CYC, 3, number of cycles flush stays asserted before redirect (legal range 1..15)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-low reset
commit_valid  input  1  an instruction commits this cycle
commit_pc  input  32  pc of the committing instruction
is_syscall  input  1  committing instruction is syscall (qualified by commit_valid)
is_eret  input  1  committing instruction is eret (qualified by commit_valid)
intr  input  6  hardware interrupt lines, level, same as CP0 intr
intimer  input  1  CP0 timer interrupt, level
status  input  32  CP0 Status value
cause  input  32  CP0 Cause value
epc  input  32  CP0 EPC value
excptype  output  32  exception code to CP0: 0x4 interrupt, 0x100 syscall, 0x200 eret, 0 none
excp_pc  output  32  pc handed to CP0 alongside excptype
flush  output  1  kill all in-flight pipeline stages
stall  output  1  freeze fetch/commit while sequencing
new_pc_valid  output  1  one-cycle fetch redirect strobe
new_pc  output  32  redirect target

Behaviour:
- All outputs are registered.
- Reset (rst=0, asynchronous): state IDLE; excptype=0, excp_pc=0, flush=0, stall=0, new_pc_valid=0, new_pc=0, drain counter=0.
- Reset asserted mid-sequence aborts the sequence immediately, with no redirect.
- Interrupt request int_req (combinational) = status[0] (IE) & ~status[1] (EXL) & |(status[15:10] & {intr[5:1], intr[0]|intimer}).
- intimer is ORed into IP2.
- int_req needs no commit_valid; it uses commit_pc as EPC when commit_valid=1. Otherwise the interrupt waits for the next commit_valid cycle.
- Priority among requests at a commit_valid cycle in IDLE: int_req > is_syscall > is_eret.
- A lower-priority request that loses is dropped. Its instruction is flushed and re-executed, because EPC = its own pc for an interrupt.
- FSM:
  - IDLE: on a request with commit_valid=1, latch code and target, go to EXC. Otherwise stay; outputs idle.
  - EXC (1 cycle):
    - excptype = latched code.
    - excp_pc = commit_pc, captured at the request edge. CP0 adds 4 for syscall itself.
    - flush=1, stall=1, drain counter loaded with DRAIN_CYC-1.
    - Next state: DRAIN, or REDIRECT when DRAIN_CYC=1.
  - DRAIN: excptype=0, flush=1, stall=1, counter decrements each cycle. At 0, go to REDIRECT.
  - REDIRECT (1 cycle): flush=0, stall=1, new_pc_valid=1, go to IDLE.
    - new_pc = EXC_VECTOR for interrupt or syscall.
    - new_pc = epc value sampled on the EXC cycle for eret, so CP0 writes are already visible.
- Latency: request at edge N → excptype valid cycle N+1 → flush high N+1..N+DRAIN_CYC → new_pc_valid at N+DRAIN_CYC+1 → IDLE at N+DRAIN_CYC+2.
- Requests while not IDLE are ignored. stall holds commit off and the pipeline is being flushed anyway.
- Back-to-back sequences: a request in the first IDLE cycle after REDIRECT is accepted normally.
- After an interrupt or syscall, CP0 sets EXL, so int_req stays 0 until eret clears it. No nesting is possible.
- eret with EXL=0 is still sequenced and redirects to epc.
- excptype is nonzero for exactly one cycle per accepted request.

Optional Feature:
- Macro EXC_SEQ_SW_INT_EN.
- Defined: software interrupts participate. int_req additionally ORs |(status[9:8] & cause[9:8]) inside the IE/EXL gating.
- Undefined: cause[9:8] and status[9:8] are ignored. Software-interrupt writes never raise an exception.

Test Plan:
- Reset then idle: rst=0 mid-DRAIN → all outputs 0 immediately; after release, no new_pc_valid without a new request.
- Syscall: status=0x1000_0001, commit_valid=1, is_syscall=1, commit_pc=0x100 → next cycle excptype=0x100, excp_pc=0x100; flush high 3 cycles; then new_pc_valid=1, new_pc=0x40.
- Timer interrupt: status=0x1000_0401, intimer=1, commit_pc=0x200 → excptype=0x4, excp_pc=0x200, new_pc=0x40. Same stimulus with status[1]=1 or status[0]=0 → no sequence.
- Eret: epc=0x104, is_eret=1 → excptype=0x200; after drain, new_pc=0x104. Request during DRAIN is ignored (single excptype pulse).
- Simultaneous: intr[2]=1 with status[12]=1, IE=1, and is_syscall=1 at commit_pc=0x300 → excptype=0x4 (not 0x100), excp_pc=0x300.
- Software interrupt: status=0x0000_0101, cause[8]=1 → excptype=0x4 with EXC_SEQ_SW_INT_EN defined; no sequence without it.
